// File: rtl/mips_pkg.sv
// Shared widths, MEM-stage state encoding and small helpers for the MIPS
// pipeline back end.
package mips_pkg;

  localparam int DATA_W_DEFAULT     = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Word accesses only: any set bit in the two LSBs is a misaligned address.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Bubble wins over load and clears every field so
// a killed slot can never write the register file.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic                  valid_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic [DATA_W-1:0]     read_data_i,
  input  logic [DATA_W-1:0]     alu_res_i,
  input  logic [REG_ADDR_W-1:0] write_reg_i,
  output logic                  valid_o,
  output logic                  reg_write_o,
  output logic                  mem_to_reg_o,
  output logic [DATA_W-1:0]     read_data_o,
  output logic [DATA_W-1:0]     alu_res_o,
  output logic [REG_ADDR_W-1:0] write_reg_o
);

  logic                  valid_q;
  logic                  reg_write_q;
  logic                  mem_to_reg_q;
  logic [DATA_W-1:0]     read_data_q;
  logic [DATA_W-1:0]     alu_res_q;
  logic [REG_ADDR_W-1:0] write_reg_q;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_res_q    <= '0;
      write_reg_q  <= '0;
    end else if (load_i) begin
      valid_q      <= valid_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
      read_data_q  <= read_data_i;
      alu_res_q    <= alu_res_i;
      write_reg_q  <= write_reg_i;
    end
  end

  assign valid_o      = valid_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign read_data_o  = read_data_q;
  assign alu_res_o    = alu_res_q;
  assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: branch resolution, data-memory access with
// timeout and misalignment detection, and upstream stall generation.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_mem_write,
  input  logic                  in_mem_read,
  input  logic                  in_branch,
  input  logic [DATA_W-1:0]     in_br_target,
  input  logic                  in_zflag,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [DATA_W-1:0]     in_data2,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     br_target,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [DATA_W-1:0]     wb_read_data,
  output logic [DATA_W-1:0]     wb_alu_res,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic                  err_timeout,
  output logic                  err_misalign,
  output logic                  dbg_state
);

  // Memory handshake: dmem_req rises on the edge leaving IDLE and holds
  // we/addr/wdata constant until the edge on which dmem_ack (a one-cycle
  // pulse) is seen in WAIT, or until the timeout edge. Acks seen outside WAIT
  // are dropped. Upstream sees stall=1 for every cycle the EX/MEM slot must
  // hold still, so it advances on the same edge that retires the access.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_to_q, err_to_d;
  logic              err_mis_q, err_mis_d;

  logic              mem_op;
  logic              misal;
  logic              wb_load;
  logic              wb_bubble;
  logic              wb_valid_in;
  logic [DATA_W-1:0] wb_rdata_in;

  assign mem_op = in_valid & (in_mem_read | in_mem_write);
  assign misal  = mem_op & addr_misaligned(in_alu_res[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_to_q  <= 1'b0;
      err_mis_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_to_q  <= err_to_d;
      err_mis_q <= err_mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_to_d    = err_to_q;
    err_mis_d   = err_mis_q;
    stall       = 1'b0;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    wb_valid_in = in_valid;
    wb_rdata_in = '0;

    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          wb_load = 1'b1;
        end else if (misal) begin
          // Misaligned access is dropped without touching memory; the slot retires as a bubble.
          err_mis_d = 1'b1;
          wb_bubble = 1'b1;
        end else begin
          stall     = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = in_mem_write;
          addr_d    = in_alu_res;
          wdata_d   = in_data2;
          wb_bubble = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          wb_load     = 1'b1;
          wb_valid_in = 1'b1;
          wb_rdata_in = we_q ? '0 : dmem_rdata;
          req_d       = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up: release the stall so the stuck instruction retires as a bubble.
          req_d     = 1'b0;
          err_to_d  = 1'b1;
          wb_bubble = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (wb_load),
    .bubble_i     (wb_bubble),
    .valid_i      (wb_valid_in),
    .reg_write_i  (in_reg_write),
    .mem_to_reg_i (in_mem_to_reg),
    .read_data_i  (wb_rdata_in),
    .alu_res_i    (in_alu_res),
    .write_reg_i  (in_write_reg),
    .valid_o      (wb_valid),
    .reg_write_o  (wb_reg_write),
    .mem_to_reg_o (wb_mem_to_reg),
    .read_data_o  (wb_read_data),
    .alu_res_o    (wb_alu_res),
    .write_reg_o  (wb_write_reg)
  );

  assign pc_src       = in_valid & in_branch & in_zflag & (state_q == ST_IDLE);
  assign br_target    = in_br_target;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign err_timeout  = err_to_q;
  assign err_misalign = err_mis_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: each instruction is expanded into its expected
// cycle-by-cycle timeline, and a negedge process compares every output.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int T  = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read;
  logic          in_branch, in_zflag;
  logic [DW-1:0] in_br_target, in_alu_res, in_data2;
  logic [RW-1:0] in_write_reg;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          stall, pc_src;
  logic [DW-1:0] br_target;
  logic          wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [DW-1:0] wb_read_data, wb_alu_res;
  logic [RW-1:0] wb_write_reg;
  logic          err_timeout, err_misalign, dbg_state;

  mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_branch(in_branch),
    .in_br_target(in_br_target), .in_zflag(in_zflag), .in_alu_res(in_alu_res),
    .in_data2(in_data2), .in_write_reg(in_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .br_target(br_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res), .wb_write_reg(wb_write_reg),
    .err_timeout(err_timeout), .err_misalign(err_misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected state (model) ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic          chk_en = 1'b0;
  logic          e_stall, e_pc_src, e_req, e_we, e_state, e_err_to, e_err_mis;
  logic [DW-1:0] e_br, e_addr, e_wdata;
  logic          e_wb_valid, e_wb_rw, e_wb_m2r, e_wb_full;
  logic [DW-1:0] e_wb_rdata, e_wb_alu;
  logic [RW-1:0] e_wb_wreg;
  int            stall_cnt, wbv_cnt, req_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_wb(input logic v, rw, m2r, input logic [DW-1:0] rd, alu,
                        input logic [RW-1:0] wreg, input logic full);
    e_wb_valid = v;  e_wb_rw  = rw;  e_wb_m2r  = m2r;
    e_wb_rdata = rd; e_wb_alu = alu; e_wb_wreg = wreg; e_wb_full = full;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, e_stall);
      chk("pc_src", pc_src, e_pc_src);
      chk("br_target", br_target, e_br);
      chk("dmem_req", dmem_req, e_req);
      if (e_req) begin
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("wb_valid", wb_valid, e_wb_valid);
      chk("wb_reg_write", wb_reg_write, e_wb_rw);
      if (e_wb_full) begin
        chk("wb_mem_to_reg", wb_mem_to_reg, e_wb_m2r);
        chk("wb_read_data", wb_read_data, e_wb_rdata);
        chk("wb_alu_res", wb_alu_res, e_wb_alu);
        chk("wb_write_reg", wb_write_reg, e_wb_wreg);
      end
      chk("err_timeout", err_timeout, e_err_to);
      chk("err_misalign", err_misalign, e_err_mis);
      chk("state", dbg_state, e_state);
      if (stall)    stall_cnt++;
      if (wb_valid) wbv_cnt++;
      if (dmem_req) req_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Applies one EX/MEM instruction and walks it to retirement.
  // For memory ops ack_d is the WAIT cycle index carrying the ack (-1 = never);
  // otherwise ack_d>0 drives a stray ack that must be ignored.
  task automatic run_instr(input logic v, rw, m2r, mw, mr, br,
                           input logic [DW-1:0] tgt, input logic z,
                           input logic [DW-1:0] alu, d2, input logic [RW-1:0] wreg,
                           input int ack_d, input logic [DW-1:0] rdata);
    logic mem_op, mis;
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_mem_write = mw;
    in_mem_read = mr; in_branch = br; in_br_target = tgt; in_zflag = z;
    in_alu_res = alu; in_data2 = d2; in_write_reg = wreg;
    dmem_rdata = $urandom;
    mem_op = v & (mr | mw);
    mis = mem_op & (alu[1:0] != 2'b00);
    e_pc_src = v & br & z;
    e_br = tgt;
    e_state = 1'b0;
    if (!mem_op || mis) begin
      dmem_ack = (ack_d > 0);
      e_stall = 1'b0;
      cycle();
      dmem_ack = 1'b0;
      if (mis) begin
        set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        e_err_mis = 1'b1;
      end else begin
        set_wb(v, rw, m2r, '0, alu, wreg, 1'b1);
      end
    end else begin
      dmem_ack = 1'($urandom_range(0, 1));
      e_stall = 1'b1;
      cycle();
      e_req = 1'b1; e_we = mw; e_addr = alu; e_wdata = d2; e_state = 1'b1;
      set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      for (int k = 0; k < T; k++) begin
        dmem_ack = (k == ack_d);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        e_stall = !dmem_ack && (k != T - 1);
        cycle();
        if (k == ack_d) begin
          e_req = 1'b0; e_state = 1'b0;
          set_wb(1'b1, rw, m2r, mw ? '0 : rdata, alu, wreg, 1'b1);
          break;
        end else if (k == T - 1) begin
          e_req = 1'b0; e_state = 1'b0; e_err_to = 1'b1;
          set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
      end
      dmem_ack = 1'b0;
    end
  endtask

  task automatic nop();
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_mem_write = 0; in_mem_read = 0;
    in_branch = 0; in_zflag = 0; in_br_target = '0; in_alu_res = '0; in_data2 = '0;
    in_write_reg = '0; dmem_ack = 0; dmem_rdata = '0;
    e_stall = 0; e_pc_src = 0; e_req = 0; e_we = 0; e_state = 0; e_err_to = 0; e_err_mis = 0;
    e_br = '0; e_addr = '0; e_wdata = '0;
    set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    stall_cnt = 0; wbv_cnt = 0; req_cnt = 0;
    cycle();
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_n = 1'b1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);

    // 1: plain ALU op
    run_instr(1, 1, 0, 0, 0, 0, '0, 0, 32'h1234, '0, 5'd7, 0, '0);
    chk("t1_wb_valid", wb_valid, 1'b1);
    chk("t1_wb_alu_res", wb_alu_res, 32'h1234);
    chk("t1_wb_write_reg", wb_write_reg, 5'd7);

    // 2: load acked 3 cycles after req
    nop();
    stall_cnt = 0; wbv_cnt = 0;
    run_instr(1, 1, 1, 0, 1, 0, '0, 0, 32'h40, '0, 5'd3, 3, 32'hDEADBEEF);
    chk("t2_wb_read_data", wb_read_data, 32'hDEADBEEF);
    nop();
    chk("t2_stall_cycles", stall_cnt, 4);
    chk("t2_wb_valid_once", wbv_cnt, 1);

    // 3: store
    run_instr(1, 0, 0, 1, 0, 0, '0, 0, 32'h44, 32'hA5A5A5A5, 5'd9, 2, '0);
    chk("t3_wb_reg_write", wb_reg_write, 1'b0);
    chk("t3_wb_read_data", wb_read_data, 32'h0);

    // 4: load never acked
    req_cnt = 0;
    run_instr(1, 1, 1, 0, 1, 0, '0, 0, 32'h80, '0, 5'd4, -1, '0);
    chk("t4_err_timeout", err_timeout, 1'b1);
    chk("t4_dmem_req", dmem_req, 1'b0);
    chk("t4_wait_cycles", req_cnt, 16);

    // 5: branch taken / not taken, combinational
    in_valid = 1; in_branch = 1; in_zflag = 1; in_br_target = 32'h100;
    in_mem_read = 0; in_mem_write = 0;
    #1;
    chk("t5_pc_src_taken", pc_src, 1'b1);
    chk("t5_br_target", br_target, 32'h100);
    in_zflag = 0;
    #1;
    chk("t5_pc_src_not_taken", pc_src, 1'b0);
    run_instr(1, 0, 0, 0, 0, 1, 32'h100, 1, 32'h5, '0, '0, 0, '0);

    // 6: reset during WAIT cycle 2, then a late ack
    run_instr(1, 1, 1, 0, 1, 0, '0, 0, 32'h48, '0, 5'd2, -2, '0);
    begin
      in_valid = 1; in_reg_write = 1; in_mem_to_reg = 1; in_mem_read = 1; in_mem_write = 0;
      in_branch = 0; in_alu_res = 32'h48; in_write_reg = 5'd2;
      e_pc_src = 0; e_stall = 1;
      cycle();
      e_req = 1; e_we = 0; e_addr = 32'h48; e_wdata = in_data2; e_state = 1;
      set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      e_req = 0; e_state = 0; e_err_to = 0; e_err_mis = 0;
      set_wb(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("t6_dmem_req", dmem_req, 1'b0);
      chk("t6_state", dbg_state, 1'b0);
      chk("t6_wb_alu_res", wb_alu_res, 32'h0);
      chk("t6_err_timeout", err_timeout, 1'b0);
    end
    run_instr(0, 0, 0, 0, 1, 0, '0, 0, 32'h48, '0, 5'd2, 1, 32'h1111);
    chk("t6_late_ack_req", dmem_req, 1'b0);
    chk("t6_late_ack_wb_valid", wb_valid, 1'b0);

    // 7: misaligned load
    run_instr(1, 1, 1, 0, 1, 0, '0, 0, 32'h41, '0, 5'd6, 0, '0);
    chk("t7_err_misalign", err_misalign, 1'b1);
    chk("t7_dmem_req", dmem_req, 1'b0);
    chk("t7_wb_valid", wb_valid, 1'b0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      int kind, ad;
      logic [DW-1:0] alu;
      logic mw, mr;
      kind = $urandom_range(0, 9);
      alu = $urandom;
      ad = $urandom_range(0, 5);
      mw = 1'($urandom_range(0, 1));
      mr = !mw;
      case (kind)
        0, 1, 2: run_instr(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 0, 0, 0,
                           $urandom, 1'($urandom), alu, $urandom, 5'($urandom), $urandom_range(0, 1), '0);
        3:       run_instr(1'($urandom_range(0, 3) != 0), 0, 0, 0, 0, 1, $urandom, 1'($urandom),
                           alu, $urandom, 5'($urandom), $urandom_range(0, 1), '0);
        4, 5, 6: run_instr(1, mr, mr, mw, mr, 0, $urandom, 0, {alu[DW-1:2], 2'b00}, $urandom,
                           5'($urandom), ad, $urandom);
        7:       run_instr(1, mr, mr, mw, mr, 0, $urandom, 0, {alu[DW-1:2], 2'($urandom_range(1, 3))},
                           $urandom, 5'($urandom), ad, $urandom);
        8:       run_instr(0, 1'($urandom), 1'($urandom), mw, mr, 0, $urandom, 0, alu, $urandom,
                           5'($urandom), $urandom_range(0, 1), '0);
        default: begin
          ad = $urandom_range(0, 2);
          ad = (ad == 0) ? -1 : ((ad == 1) ? T - 1 : T - 2);
          run_instr(1, mr, mr, mw, mr, 0, $urandom, 0, {alu[DW-1:2], 2'b00}, $urandom,
                    5'($urandom), ad, $urandom);
        end
      endcase
    end
    nop();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end

endmodule
